// File: rtl/tlb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tlb_rr_arbiter
//
// Purpose:
//   Shares one TLB lookup port among N_SRC translation requesters. A single
//   lookup is in flight at a time. Sources are served in round-robin order
//   starting from the source after the one most recently completed. The PPN
//   goes back to the granted source through a registered, one-cycle response.
//
// Optional feature (macro TLB_ARB_TIMEOUT_EN):
//   When defined, a watchdog aborts a lookup that has waited TIMEOUT_CYCLES
//   cycles in S_REQ without sink_ack. The source then gets a fault response
//   (src_fault=1, src_ppn=0), so a stuck TLB cannot hang every requester.
//   When undefined, there is no counter, src_fault is tied low and S_REQ
//   waits for sink_ack indefinitely.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   src_valid  per-source request valid                       [N_SRC]
//   src_vpn    per-source VPN, source i at [i*VPN_W +: VPN_W] [N_SRC*VPN_W]
//   src_ack    one-hot, one-cycle response strobe            [N_SRC]
//   src_ppn    response PPN, valid with src_ack              [PPN_W]
//   src_fault  response is a timeout fault, valid with src_ack
//   sink_valid lookup request to the TLB
//   sink_vpn   lookup VPN                                    [VPN_W]
//   sink_ack   TLB lookup done
//   sink_ppn   TLB result, valid with sink_ack               [PPN_W]
//   busy       high whenever the arbiter is not idle
//   grant_idx  source currently or most recently granted     [IW]
// ---------------------------------------------------------------------------
module tlb_rr_arbiter #(
  parameter int N_SRC          = 4,
  parameter int VPN_W          = 52,
  parameter int PPN_W          = 44,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IW            = (N_SRC > 2) ? $clog2(N_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [N_SRC*VPN_W-1:0] src_vpn,
  output logic [N_SRC-1:0]       src_ack,
  output logic [PPN_W-1:0]       src_ppn,
  output logic                   src_fault,
  output logic                   sink_valid,
  output logic [VPN_W-1:0]       sink_vpn,
  input  logic                   sink_ack,
  input  logic [PPN_W-1:0]       sink_ppn,
  output logic                   busy,
  output logic [IW-1:0]          grant_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N_SRC - 1);

  state_t            state;
  state_t            state_nxt;

  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     grant_r;
  logic [VPN_W-1:0]  vpn_r;
  logic [PPN_W-1:0]  ppn_r;

  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic [IW:0]       cand;
  logic [VPN_W-1:0]  pick_vpn;
  logic [IW-1:0]     ptr_after_grant;
  logic              req_done;

`ifdef TLB_ARB_TIMEOUT_EN
  // Wide enough to hold TIMEOUT_CYCLES-1, the last count before expiry.
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0]     wd_cnt;
  logic              fault_r;
  logic              timeout_hit;

  // Expiry only counts when the TLB has not answered in the same cycle;
  // a simultaneous sink_ack always wins over the watchdog.
  assign timeout_hit = (state == S_REQ) && !sink_ack &&
                       (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  // Round-robin search: walk upward from rr_ptr, wrapping modulo N_SRC,
  // and take the first valid source. The candidate is one bit wider than
  // an index so the wrap works for non-power-of-two N_SRC too.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_SRC)) begin
        cand = cand - (IW+1)'(N_SRC);
      end
      if (!pick_found && src_valid[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  assign pick_vpn = src_vpn[int'(pick_idx) * VPN_W +: VPN_W];

  // Next round-robin start point: the source after the one just served.
  assign ptr_after_grant = (grant_r == LAST_IDX) ? '0 : grant_r + IW'(1);

  // A lookup leaves S_REQ either on the TLB answer or on watchdog expiry.
`ifdef TLB_ARB_TIMEOUT_EN
  assign req_done = sink_ack || timeout_hit;
`else
  assign req_done = sink_ack;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. S_RESP always falls back to S_IDLE, so a source that
  // still shows valid in its ack cycle is not granted a second time.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (req_done) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic. Everything here depends only on state and registers, so
  // the TLB side never sees a combinational path from the src_* inputs.
  always_comb begin
    busy       = (state != S_IDLE);
    sink_valid = (state == S_REQ);
    src_ack    = '0;
    for (int i = 0; i < N_SRC; i++) begin
      src_ack[i] = (state == S_RESP) && (grant_r == IW'(i));
    end
  end

  assign sink_vpn  = vpn_r;
  assign src_ppn   = ppn_r;
  assign grant_idx = grant_r;

`ifdef TLB_ARB_TIMEOUT_EN
  assign src_fault = fault_r;
`else
  assign src_fault = 1'b0;
`endif

  // Datapath registers. The grant and the VPN are captured once, at the
  // moment the source is granted. Later VPN changes on the source side
  // do not disturb the lookup in flight. The round-robin pointer only
  // moves when a lookup finishes, so a reset mid-lookup restarts the
  // search from source 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      grant_r <= '0;
      vpn_r   <= '0;
      ppn_r   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_r <= pick_idx;
            vpn_r   <= pick_vpn;
          end
        end
        S_REQ: begin
          if (sink_ack) begin
            ppn_r  <= sink_ppn;
            rr_ptr <= ptr_after_grant;
          end
`ifdef TLB_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            ppn_r  <= '0;
            rr_ptr <= ptr_after_grant;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

`ifdef TLB_ARB_TIMEOUT_EN
  // Watchdog counter and fault flag. The counter restarts on every entry
  // to S_REQ and advances once per unanswered S_REQ cycle. The fault flag
  // describes the most recent completion and holds until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      fault_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          wd_cnt <= '0;
        end
        S_REQ: begin
          if (sink_ack) begin
            fault_r <= 1'b0;
          end else if (timeout_hit) begin
            fault_r <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end
`endif

endmodule
